// File: rtl/flash_access_sequencer.sv
// Flash access sequencer: wait-state-timed flash strobes and local /DTACK for the
// Kickstart flash window, plus JEDEC command tracking with program/erase busy timing.
module flash_access_sequencer #(
  parameter int WAIT_STATES  = 2,
  parameter int PROG_TICKS   = 142,
  parameter int SECTOR_TICKS = 3545000,
  parameter int ERASE_TICKS  = 14180000
) (
  input  logic        MB_CLK,
  input  logic        RESET,
  input  logic        CPU_AS,
  input  logic        FLASH_SEL,
  input  logic        RW,
  input  logic        UDS,
  input  logic        LDS,
  input  logic [10:0] ADDRESS,
  input  logic [7:0]  DATA_IN,
  output logic [1:0]  FLASH_RD,
  output logic [1:0]  FLASH_WR,
  output logic        DTACK,
  output logic        BUSY,
  output logic        CMD_DONE
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} bus_t;
  typedef enum logic [2:0] {C_IDLE, C_U1, C_U2, C_PROG, C_E1, C_E2, C_E3} cmd_t;

  localparam logic [4:0]  WS        = 5'(WAIT_STATES);
  localparam logic [23:0] PROG_V    = 24'(PROG_TICKS);
  localparam logic [23:0] SECTOR_V  = 24'(SECTOR_TICKS);
  localparam logic [23:0] ERASE_V   = 24'(ERASE_TICKS);

  bus_t        bus_q, bus_d;
  cmd_t        cmd_q, cmd_d;
  logic [3:0]  wait_q, wait_d;
  logic        rw_q, rw_d;
  logic [1:0]  lanes_q, lanes_d;
  logic [10:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [1:0]  rd_q, rd_d;
  logic [1:0]  wr_q, wr_d;
  logic        dtack_q, dtack_d;
  logic [23:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        cmd_step;
  logic        load;
  logic [23:0] load_val;
  logic        at_555, at_2aa;

  assign at_555 = (addr_q == 11'h555);
  assign at_2aa = (addr_q == 11'h2AA);

  always_comb begin
    bus_d    = bus_q;
    wait_d   = wait_q;
    rw_d     = rw_q;
    lanes_d  = lanes_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    dtack_d  = dtack_q;
    cmd_step = 1'b0;
    unique case (bus_q)
      IDLE: begin
        if (!CPU_AS && FLASH_SEL && !(UDS && LDS)) begin
          bus_d   = ACCESS;
          rw_d    = RW;
          lanes_d = {UDS, LDS};
          addr_d  = ADDRESS;
          data_d  = DATA_IN;
          wait_d  = 4'd0;
          if (RW) rd_d = {UDS, LDS};
          else    wr_d = {UDS, LDS};
        end
      end
      ACCESS: begin
        if (CPU_AS) begin
          bus_d = IDLE;
          rd_d  = 2'b11;
          wr_d  = 2'b11;
        end else if ({1'b0, wait_q} + 5'd1 >= WS) begin
          // WAIT_STATES of 0 or 1 both acknowledge on the first edge after the strobes
          bus_d    = ACK;
          dtack_d  = 1'b0;
          cmd_step = !rw_q && !lanes_q[0] && !busy_q;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      ACK: begin
        if (CPU_AS) begin
          bus_d   = IDLE;
          rd_d    = 2'b11;
          wr_d    = 2'b11;
          dtack_d = 1'b1;
        end
      end
      default: bus_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_d    = cmd_q;
    load     = 1'b0;
    load_val = 24'd0;
    if (cmd_step) begin
      cmd_d = C_IDLE;
      // F0 is the JEDEC reset command and wins over every other decode
      if (data_q != 8'hF0) begin
        unique case (cmd_q)
          C_IDLE: if (data_q == 8'hAA && at_555) cmd_d = C_U1;
          C_U1:   if (data_q == 8'h55 && at_2aa) cmd_d = C_U2;
          C_U2: begin
            if (data_q == 8'hA0 && at_555)      cmd_d = C_PROG;
            else if (data_q == 8'h80 && at_555) cmd_d = C_E1;
          end
          C_PROG: begin
            load     = 1'b1;
            load_val = PROG_V;
          end
          C_E1:   if (data_q == 8'hAA && at_555) cmd_d = C_E2;
          C_E2:   if (data_q == 8'h55 && at_2aa) cmd_d = C_E3;
          C_E3: begin
            if (data_q == 8'h10 && at_555) begin
              load     = 1'b1;
              load_val = ERASE_V;
            end else if (data_q == 8'h30) begin
              load     = 1'b1;
              load_val = SECTOR_V;
            end
          end
          default: cmd_d = C_IDLE;
        endcase
      end
    end
    if (load)             cnt_d = load_val;
    else if (cnt_q != 0)  cnt_d = cnt_q - 24'd1;
    else                  cnt_d = cnt_q;
    busy_d = (cnt_q != 24'd0);
    done_d = busy_q && (cnt_q == 24'd0);
  end

  always_ff @(posedge MB_CLK or posedge RESET) begin
    if (RESET) begin
      bus_q   <= IDLE;
      cmd_q   <= C_IDLE;
      wait_q  <= 4'd0;
      rw_q    <= 1'b1;
      lanes_q <= 2'b11;
      addr_q  <= 11'd0;
      data_q  <= 8'd0;
      rd_q    <= 2'b11;
      wr_q    <= 2'b11;
      dtack_q <= 1'b1;
      cnt_q   <= 24'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      bus_q   <= bus_d;
      cmd_q   <= cmd_d;
      wait_q  <= wait_d;
      rw_q    <= rw_d;
      lanes_q <= lanes_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      dtack_q <= dtack_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign FLASH_RD = rd_q;
  assign FLASH_WR = wr_q;
  assign DTACK    = dtack_q;
  assign BUSY     = busy_q;
  assign CMD_DONE = done_q;

endmodule

// File: doc/flash_access_sequencer.md
Name: flash_access_sequencer

Overview:
Downstream stage of the Kickstart relocator's address decode. It consumes the decoded "flash selected" qualifier plus raw 68000 bus strobes. It produces registered, wait-state-timed flash byte-lane strobes and a local /DTACK. It also tracks JEDEC command sequences on flash writes and flags program/erase busy windows for the programming session. Everything runs in the 7 MHz motherboard clock domain.

Parameters:
WAIT_STATES, 2, MB_CLK cycles between strobe assertion and /DTACK assertion (0..15)
PROG_TICKS, 142, busy duration after a word-program command (about 20 us at 7.09 MHz)
SECTOR_TICKS, 3545000, busy duration after a sector-erase command (about 0.5 s)
ERASE_TICKS, 14180000, busy duration after a chip-erase command (about 2 s; must fit 24 bits)

Ports:
MB_CLK  in  1  7 MHz motherboard clock, all state on rising edge
RESET  in  1  asynchronous, active-high reset
CPU_AS  in  1  CPU /AS, active low
FLASH_SEL  in  1  decoded flash window hit, active high, valid while CPU_AS=0
RW  in  1  1=read, 0=write
UDS  in  1  upper data strobe, active low
LDS  in  1  lower data strobe, active low
ADDRESS  in  11  CPU A[11:1], word address for command decode
DATA_IN  in  8  CPU D[7:0], sampled on writes
FLASH_RD  out  2  {upper,lower} flash /OE per lane, active low
FLASH_WR  out  2  {upper,lower} flash /WE per lane, active low
DTACK  out  1  local /DTACK, active low (the parent drives the open-drain pin)
BUSY  out  1  program/erase in progress
CMD_DONE  out  1  one-cycle pulse when BUSY falls

Behaviour:
Reset values:
- FLASH_RD=2'b11, FLASH_WR=2'b11, DTACK=1, BUSY=0, CMD_DONE=0.
- Bus FSM=IDLE, command FSM=C_IDLE, busy counter=0.
- Reset mid-cycle or mid-busy aborts immediately, with no CMD_DONE.

Bus FSM (IDLE, ACCESS, ACK):
- IDLE -> ACCESS on an edge where CPU_AS=0, FLASH_SEL=1 and ~(UDS&LDS).
  - Latch RW, {UDS,LDS}, ADDRESS, DATA_IN.
  - Set the wait counter to 0.
  - Strobes go low on that same edge: FLASH_RD={UDS,LDS} if RW=1, else FLASH_WR={UDS,LDS}.
- ACCESS: the wait counter increments each edge. When it equals WAIT_STATES, go to ACK and drive DTACK=0 on that edge. With WAIT_STATES=0, DTACK falls one edge after the strobes.
- ACK: hold the strobes and DTACK until an edge sees CPU_AS=1. That edge deasserts everything to 1 and returns to IDLE.
- Abort: CPU_AS=1 in ACCESS returns to IDLE with strobes=11. No DTACK is issued and the command tracker does not see the cycle.
- No re-entry into ACCESS on the edge that closes a cycle; a new cycle needs an IDLE edge first.
- Reads and writes are never suppressed by BUSY (status polling and reset commands must reach the flash).

Command FSM:
- Advances only on the ACCESS->ACK edge of a write with the lower lane active (latched LDS=0) and BUSY=0.
- a = latched ADDRESS, d = latched DATA_IN.
- C_IDLE: AA@555 -> C_U1.
- C_U1: 55@2AA -> C_U2.
- C_U2: A0@555 -> C_PROG; 80@555 -> C_E1.
- C_PROG: any write -> load counter with PROG_TICKS, C_IDLE.
- C_E1: AA@555 -> C_E2.
- C_E2: 55@2AA -> C_E3.
- C_E3: 10@555 -> load ERASE_TICKS; 30@any address -> load SECTOR_TICKS; then C_IDLE.
- Any non-matching write, or d=F0 at any address, -> C_IDLE.
- Upper-lane-only writes and all reads leave the state unchanged.

Busy counter:
- 24-bit, loaded on the edges above.
- BUSY is registered and equals 1 whenever the counter is non-zero. It rises on the edge after the load.
- Decrements once per MB_CLK while non-zero.
- On the 1->0 transition, CMD_DONE=1 for exactly one cycle.
- Writes while BUSY=1 do not reload, extend or restart the counter.

Test Plan:
1. WAIT_STATES=2, read at a flash address, UDS=LDS=0 → FLASH_RD=00 on edge N, DTACK=0 on edge N+2, both back to 1 on the first edge after CPU_AS rises; FLASH_WR stays 11.
2. Byte write with LDS=0, UDS=1 → FLASH_WR=10 and FLASH_RD=11 throughout; DTACK timing as in scenario 1.
3. Writes AA@555, 55@2AA, A0@555, then 1234@0100 → BUSY=1 from the edge after the fourth ACK, held for 142 cycles; CMD_DONE pulses once.
4. Six-write sector-erase sequence ending 30@0400 with SECTOR_TICKS overridden to 50 → BUSY high for 50 cycles. A seventh write during BUSY does not extend it.
5. AA@555 then 56@2AA, then A0@555 → no BUSY. AA@555, 55@2AA, F0@000 → command FSM at C_IDLE.
6. CPU_AS released at ACCESS+1 → no DTACK, command FSM unchanged. Assert RESET with BUSY=1 → all outputs at reset values within the same cycle, with no CMD_DONE.
